// File: rtl/noise_table_ctrl_pkg.sv
// Shared constants and state encoding for the CDF noise-table sequencer.
package noise_ctrl_pkg;
    localparam int N_ENTRIES   = 128;
    localparam int DATA_W      = 64;
    localparam int N_BANKS     = 4;
    localparam int BANK_W      = $clog2(N_BANKS);
    localparam int GEN_RST_CYC = 2;
    localparam int PAD_MAX     = 8;
    localparam int CNT_W       = 32;
    localparam int ENT_W       = 7;
    localparam int LOC_W       = 8;
    localparam int ADDR_W      = BANK_W + ENT_W;

    typedef enum logic [2:0] {IDLE, GRST, LOAD, PAD, RUN, DONE, ERR} state_e;
endpackage

// File: rtl/noise_table_ctrl_if.sv
// ROM read port plus noise-generator control/load port, seen from the sequencer (master).
interface noise_table_ctrl_if;
    import noise_ctrl_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_data;
    logic              gen_rstn;
    logic              gen_load_mem;
    logic [LOC_W-1:0]  gen_location;
    logic [DATA_W-1:0] gen_mem_data;
    logic              gen_done_wait;
    logic              gen_en;
    logic              gen_valid;

    modport master (
        output rom_addr, rom_rd, gen_rstn, gen_load_mem, gen_location, gen_mem_data, gen_en,
        input  rom_data, gen_done_wait, gen_valid
    );
    modport slave (
        input  rom_addr, rom_rd, gen_rstn, gen_load_mem, gen_location, gen_mem_data, gen_en,
        output rom_data, gen_done_wait, gen_valid
    );
endinterface

// File: rtl/noise_table_ctrl.sv
// Sequencer: resets the noise generator, streams one CDF bank from ROM, then runs it for N samples.
module noise_table_ctrl
    import noise_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [CNT_W-1:0]  sample_target,
    input  logic              stop,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  samples,
    noise_table_ctrl_if.master gen
);

    state_e            state, state_n;
    logic [BANK_W-1:0] bank_q, bank_n;
    logic [CNT_W-1:0]  target_q, target_n;
    logic [3:0]        wcnt, wcnt_n;
    logic [7:0]        rd_cnt, rd_cnt_n;
    logic              rd_d, rd_d_n;
    logic [ENT_W-1:0]  loc_d, loc_d_n;

    logic [ADDR_W-1:0] rom_addr_n;
    logic              rom_rd_n, rstn_n, ld_n, en_n, busy_n, done_n, err_n;
    logic [LOC_W-1:0]  loc_n;
    logic [DATA_W-1:0] data_n;
    logic [CNT_W-1:0]  samples_n, sample_inc;

    always_comb begin
        state_n    = state;
        bank_n     = bank_q;
        target_n   = target_q;
        wcnt_n     = wcnt;
        rd_cnt_n   = rd_cnt;
        // ROM data lags the read strobe by one cycle; carry the strobe and index alongside it
        rd_d_n     = gen.rom_rd;
        loc_d_n    = gen.rom_addr[ENT_W-1:0];
        rom_rd_n   = 1'b0;
        rom_addr_n = gen.rom_addr;
        rstn_n     = gen.gen_rstn;
        ld_n       = 1'b0;
        loc_n      = gen.gen_location;
        data_n     = gen.gen_mem_data;
        en_n       = 1'b0;
        done_n     = done;
        err_n      = err;
        samples_n  = samples;
        sample_inc = (samples == '1) ? samples : samples + CNT_W'(1);

        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_n   = GRST;
                    bank_n    = bank_sel;
                    target_n  = sample_target;
                    wcnt_n    = '0;
                    samples_n = '0;
                    done_n    = 1'b0;
                    err_n     = 1'b0;
                    rstn_n    = 1'b0;
                end
            end
            GRST: begin
                rstn_n = 1'b0;
                wcnt_n = wcnt + 4'd1;
                if (wcnt == 4'(GEN_RST_CYC - 1)) begin
                    state_n    = LOAD;
                    rstn_n     = 1'b1;
                    rom_rd_n   = 1'b1;
                    rom_addr_n = {bank_q, ENT_W'(0)};
                    rd_cnt_n   = 8'd1;
                end
            end
            LOAD: begin
                if (rd_cnt < 8'(N_ENTRIES)) begin
                    rom_rd_n   = 1'b1;
                    rom_addr_n = {bank_q, rd_cnt[ENT_W-1:0]};
                    rd_cnt_n   = rd_cnt + 8'd1;
                end
                if (rd_d) begin
                    ld_n   = 1'b1;
                    loc_n  = {1'b0, loc_d};
                    data_n = gen.rom_data;
                end
                // last entry is on the bus: keep strobing it until the generator acknowledges
                if (gen.gen_load_mem && gen.gen_location == LOC_W'(N_ENTRIES - 1)) begin
                    state_n = PAD;
                    ld_n    = 1'b1;
                    wcnt_n  = '0;
                end
            end
            PAD: begin
                ld_n   = 1'b1;
                wcnt_n = wcnt + 4'd1;
                if (gen.gen_done_wait) begin
                    state_n = RUN;
                    ld_n    = 1'b0;
                    en_n    = !pause;
                end else if (wcnt == 4'(PAD_MAX - 1)) begin
                    state_n = ERR;
                    ld_n    = 1'b0;
                    err_n   = 1'b1;
                end
            end
            RUN: begin
                en_n = !pause;
                if (gen.gen_valid) samples_n = sample_inc;
                if (stop || (target_q != '0 && gen.gen_valid && sample_inc == target_q)) begin
                    state_n = DONE;
                    en_n    = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = state_n inside {GRST, LOAD, PAD, RUN};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bank_q           <= '0;
            target_q         <= '0;
            wcnt             <= '0;
            rd_cnt           <= '0;
            rd_d             <= 1'b0;
            loc_d            <= '0;
            gen.rom_rd       <= 1'b0;
            gen.rom_addr     <= '0;
            gen.gen_rstn     <= 1'b0;
            gen.gen_load_mem <= 1'b0;
            gen.gen_location <= '0;
            gen.gen_mem_data <= '0;
            gen.gen_en       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            samples          <= '0;
        end else begin
            state            <= state_n;
            bank_q           <= bank_n;
            target_q         <= target_n;
            wcnt             <= wcnt_n;
            rd_cnt           <= rd_cnt_n;
            rd_d             <= rd_d_n;
            loc_d            <= loc_d_n;
            gen.rom_rd       <= rom_rd_n;
            gen.rom_addr     <= rom_addr_n;
            gen.gen_rstn     <= rstn_n;
            gen.gen_load_mem <= ld_n;
            gen.gen_location <= loc_n;
            gen.gen_mem_data <= data_n;
            gen.gen_en       <= en_n;
            busy             <= busy_n;
            done             <= done_n;
            err              <= err_n;
            samples          <= samples_n;
        end
    end

endmodule

// File: tb/tb_noise_table_ctrl.sv
// Randomized bench for noise_table_ctrl with behavioural ROM and generator models.
module tb_noise_table_ctrl;
    import noise_ctrl_pkg::*;

    localparam int CAPN = 160;

    logic              clk = 1'b0;
    logic              rst, start, stop, pause;
    logic [BANK_W-1:0] bank_sel;
    logic [CNT_W-1:0]  sample_target;
    logic              busy, done, err;
    logic [CNT_W-1:0]  samples;
    logic              dw_en;
    int                pulses;
    int                n_tests = 0;
    int                n_fail  = 0;

    logic              cap_ld[CAPN], cap_dw[CAPN], cap_rstn[CAPN], cap_err[CAPN], cap_en[CAPN], cap_busy[CAPN];
    logic [LOC_W-1:0]  cap_loc[CAPN];
    logic [DATA_W-1:0] cap_data[CAPN];
    logic [CNT_W-1:0]  cap_samples[CAPN];

    noise_table_ctrl_if ifc();

    noise_table_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .sample_target(sample_target),
        .stop(stop), .pause(pause), .busy(busy), .done(done), .err(err), .samples(samples),
        .gen(ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_val(int b, int k);
        return (64'(b) << 56) | 64'(k * 1000);
    endfunction

    // ROM with one cycle of read latency
    always @(posedge clk)
        if (ifc.rom_rd) ifc.rom_data <= rom_val(int'(ifc.rom_addr[8:7]), int'(ifc.rom_addr[6:0]));

    // generator: table is loaded once 129 load pulses have arrived since its reset
    always @(posedge clk)
        if (rst || !ifc.gen_rstn) pulses <= 0;
        else if (ifc.gen_load_mem) pulses <= pulses + 1;
    assign ifc.gen_done_wait = dw_en && (pulses >= 129);

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_start(int b, logic [CNT_W-1:0] t);
        bank_sel = BANK_W'(b); sample_target = t; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic capture(int vld_cycles);
        for (int i = 0; i < CAPN; i++) begin
            ifc.gen_valid = (i < vld_cycles);
            cap_ld[i] = ifc.gen_load_mem; cap_loc[i] = ifc.gen_location; cap_data[i] = ifc.gen_mem_data;
            cap_dw[i] = ifc.gen_done_wait; cap_rstn[i] = ifc.gen_rstn; cap_err[i] = err;
            cap_en[i] = ifc.gen_en; cap_busy[i] = busy; cap_samples[i] = samples;
            step();
        end
        ifc.gen_valid = 1'b0;
    endtask

    // length of the in-order beat run starting at the first load strobe
    function automatic int good_beats(int bank, output int f);
        int n = 0;
        f = -1;
        for (int i = 0; i < CAPN; i++) if (cap_ld[i] && f < 0) f = i;
        if (f < 0) return 0;
        for (int k = 0; k < N_ENTRIES && f + k < CAPN; k++) begin
            if (!(cap_ld[f+k] && cap_loc[f+k] == 8'(k) && cap_data[f+k] == rom_val(bank, k))) break;
            n++;
        end
        return n;
    endfunction

    function automatic int rstn_low_run();
        int n = 0;
        while (n < CAPN && !cap_rstn[n]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; step(); step(); step();
        n_tests++; if ({ifc.gen_rstn, ifc.gen_load_mem, ifc.gen_en, ifc.rom_rd, busy, done, err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000", {ifc.gen_rstn, ifc.gen_load_mem, ifc.gen_en, ifc.rom_rd, busy, done, err}); end
        n_tests++; if ({ifc.gen_location, ifc.gen_mem_data, ifc.rom_addr, samples} !== '0) begin
            n_fail++; $display("FAIL reset_buses: loc=%0d data=%h addr=%0d samples=%0d want all 0", ifc.gen_location, ifc.gen_mem_data, ifc.rom_addr, samples); end
        rst = 1'b0; step();
    endtask

    task automatic test_load_run();
        int f, d, n, nv, early, pad_bad;
        do_start(2, 10);
        capture(100);
        n = rstn_low_run();
        n_tests++; if (n != GEN_RST_CYC) begin n_fail++; $display("FAIL grst_len: got %0d want %0d", n, GEN_RST_CYC); end
        n = good_beats(2, f);
        n_tests++; if (n != N_ENTRIES) begin n_fail++; $display("FAIL load_beats: got %0d want %0d", n, N_ENTRIES); end
        d = -1; pad_bad = 0;
        for (int i = f + N_ENTRIES; f >= 0 && i < CAPN - 1 && d < 0; i++) begin
            if (!cap_ld[i] || cap_loc[i] != 8'(N_ENTRIES - 1) || cap_data[i] != rom_val(2, N_ENTRIES - 1)) pad_bad++;
            if (cap_dw[i]) d = i;
        end
        n_tests++; if (d < 0 || pad_bad != 0) begin n_fail++; $display("FAIL pad_beats: dw_idx=%0d bad=%0d want dw seen, 0 bad", d, pad_bad); end
        n_tests++; if (d < 0 || cap_ld[d+1] !== 1'b0) begin n_fail++; $display("FAIL pad_exit: load_mem after done_wait still high (idx %0d) want 0", d); end
        n_tests++; if (samples !== '0) begin n_fail++; $display("FAIL valid_outside_run: samples=%0d want 0", samples); end
        nv = 0; early = 0;
        for (int c = 0; c < 400 && nv < 10; c++) begin
            ifc.gen_valid = 1'($urandom_range(0, 1));
            if (ifc.gen_valid) nv++;
            step();
            if (nv < 10 && done) early++;
        end
        ifc.gen_valid = 1'b0;
        n_tests++; if (!(done === 1'b1 && busy === 1'b0 && early == 0)) begin n_fail++; $display("FAIL target_done: done=%b busy=%b early=%0d want 1 0 0", done, busy, early); end
        n_tests++; if (samples !== 32'd10) begin n_fail++; $display("FAIL target_samples: got %0d want 10", samples); end
        ifc.gen_valid = 1'b1; step(); step(); step(); ifc.gen_valid = 1'b0;
        n_tests++; if (samples !== 32'd10 || done !== 1'b1 || ifc.gen_en !== 1'b0) begin
            n_fail++; $display("FAIL done_hold: samples=%0d done=%b en=%b want 10 1 0", samples, done, ifc.gen_en); end
    endtask

    task automatic test_pad_timeout();
        int f, e, n, b;
        b = $urandom_range(0, 3);
        dw_en = 1'b0;
        do_start(b, 0);
        capture(0);
        n = good_beats(b, f);
        e = -1;
        for (int i = 0; i < CAPN; i++) if (cap_err[i] && e < 0) e = i;
        n_tests++; if (f < 0 || e != f + N_ENTRIES + PAD_MAX) begin n_fail++; $display("FAIL err_time: got idx %0d want %0d", e, f + N_ENTRIES + PAD_MAX); end
        n_tests++; if (e < 0 || cap_ld[e] !== 1'b0 || cap_en[e] !== 1'b0 || cap_busy[e] !== 1'b0) begin
            n_fail++; $display("FAIL err_outputs: idx=%0d want load_mem=0 en=0 busy=0", e); end
        dw_en = 1'b1;
        b = $urandom_range(0, 3);
        do_start(b, 0);
        capture(0);
        n = good_beats(b, f);
        n_tests++; if (cap_err[0] !== 1'b0 || n != N_ENTRIES) begin n_fail++; $display("FAIL err_reload: err=%b beats=%0d want 0 %0d", cap_err[0], n, N_ENTRIES); end
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_reload_stop: done=%b want 1", done); end
    endtask

    task automatic test_pause_stop();
        int nv, en_bad;
        logic p;
        do_start($urandom_range(0, 3), 0);
        capture(0);
        nv = 0; en_bad = 0;
        for (int c = 0; c < 400 && nv < 37; c++) begin
            pause = ((c / 5) % 2) == 1;
            ifc.gen_valid = 1'($urandom_range(0, 1));
            if (ifc.gen_valid) nv++;
            p = pause;
            step();
            if (ifc.gen_en !== !p) en_bad++;
        end
        ifc.gen_valid = 1'b0;
        n_tests++; if (en_bad != 0 || done !== 1'b0) begin n_fail++; $display("FAIL pause_en: en mismatches=%0d done=%b want 0 0", en_bad, done); end
        stop = 1'b1; step(); stop = 1'b0; pause = 1'b0;
        n_tests++; if (done !== 1'b1 || samples !== 32'd37 || ifc.gen_en !== 1'b0) begin
            n_fail++; $display("FAIL stop_done: done=%b samples=%0d en=%b want 1 37 0", done, samples, ifc.gen_en); end
    endtask

    task automatic test_reset_mid_load();
        int f, n, b;
        bit found = 0;
        do_start($urandom_range(0, 3), 0);
        for (int c = 0; c < 200 && !found; c++) begin
            if (ifc.gen_load_mem && ifc.gen_location == 8'd60) found = 1;
            else step();
        end
        rst = 1'b1; step(); rst = 1'b0;
        n_tests++; if (!found || {ifc.gen_rstn, ifc.gen_load_mem, ifc.gen_en, ifc.rom_rd, busy, done, err} !== 7'b0
                       || {ifc.gen_location, ifc.gen_mem_data, ifc.rom_addr, samples} !== '0) begin
            n_fail++; $display("FAIL mid_load_reset: found=%0d ld=%b loc=%0d addr=%0d busy=%b want all reset", found, ifc.gen_load_mem, ifc.gen_location, ifc.rom_addr, busy); end
        b = $urandom_range(0, 3);
        do_start(b, 0);
        capture(0);
        n = good_beats(b, f);
        n_tests++; if (n != N_ENTRIES) begin n_fail++; $display("FAIL reload_beats: got %0d want %0d", n, N_ENTRIES); end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_stop_at_target();
        int nv;
        do_start($urandom_range(0, 3), 5);
        capture(0);
        do_start(1, 99);
        n_tests++; if (busy !== 1'b1 || ifc.gen_rstn !== 1'b1 || ifc.rom_rd !== 1'b0) begin
            n_fail++; $display("FAIL start_busy_ignored: busy=%b rstn=%b rom_rd=%b want 1 1 0", busy, ifc.gen_rstn, ifc.rom_rd); end
        nv = 0;
        for (int c = 0; c < 400 && nv < 5; c++) begin
            ifc.gen_valid = 1'($urandom_range(0, 1));
            if (ifc.gen_valid) nv++;
            stop = (nv == 5);
            step();
        end
        ifc.gen_valid = 1'b0; stop = 1'b0;
        n_tests++; if (done !== 1'b1 || samples !== 32'd5) begin n_fail++; $display("FAIL stop_and_target: done=%b samples=%0d want 1 5", done, samples); end
    endtask

    task automatic test_bank_switch();
        int f, n, nv;
        logic [CNT_W-1:0] tgt;
        tgt = CNT_W'($urandom_range(3, 15));
        do_start(3, tgt);
        capture(0);
        n = rstn_low_run();
        n_tests++; if (n != GEN_RST_CYC) begin n_fail++; $display("FAIL bank3_grst: got %0d want %0d", n, GEN_RST_CYC); end
        n_tests++; if (cap_samples[0] !== '0) begin n_fail++; $display("FAIL bank3_samples_clr: got %0d want 0", cap_samples[0]); end
        n = good_beats(3, f);
        n_tests++; if (n != N_ENTRIES) begin n_fail++; $display("FAIL bank3_beats: got %0d want %0d", n, N_ENTRIES); end
        nv = 0;
        for (int c = 0; c < 400 && nv < int'(tgt); c++) begin
            ifc.gen_valid = 1'($urandom_range(0, 1));
            if (ifc.gen_valid) nv++;
            step();
        end
        ifc.gen_valid = 1'b0;
        n_tests++; if (done !== 1'b1 || samples !== tgt) begin n_fail++; $display("FAIL bank3_run: done=%b samples=%0d want 1 %0d", done, samples, tgt); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; bank_sel = '0; sample_target = '0;
        ifc.gen_valid = 1'b0; dw_en = 1'b1;
        test_reset();
        test_load_run();
        test_pad_timeout();
        test_pause_stop();
        test_reset_mid_load();
        test_stop_at_target();
        test_bank_switch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
